// File: rtl/io_pkg.sv
// io_pkg: shared IObus constants for the switch input path.
package io_pkg;
    localparam int SW_WIDTH            = 24;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int SW_CNT_W            = 18;
    localparam logic [31:0] IO_SWITCH_ADDR      = 32'h8000_0008;
    localparam logic [31:0] IO_SWITCH_STAT_ADDR = 32'h8000_000C;
endpackage

// File: rtl/switch_debounce_bit.sv
// switch_debounce_bit: 2-flop synchronizer, stability counter and edge pulses for one switch.
module switch_debounce_bit
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = SW_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_i,
    output logic switch_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
    logic rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        sync1_d  = switch_i;
        sync2_d  = sync1_q;
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
                fall_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    assign switch_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: debounced board switches with edge pulses, sticky change flag and IRQ.
// Define SWITCH_DEBOUNCE_IRQ_EN to drive irq_o from change_o & irq_en_i; otherwise irq_o is 0.
module switch_debounce
    import io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = SW_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch_i,
    input  logic             clr_i,
    input  logic             irq_en_i,
    output logic [WIDTH-1:0] switch_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             change_o,
    output logic             irq_o
);
    logic change_q, change_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .switch_i(switch_i[i]),
            .switch_o(switch_o[i]),
            .rise_o  (rise_o[i]),
            .fall_o  (fall_o[i])
        );
    end

    // A new event beats a simultaneous clear so nothing is lost.
    always_comb begin
        change_d = (|rise_o) | (|fall_o) | (change_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) change_q <= 1'b0;
        else        change_q <= change_d;
    end

    assign change_o = change_q;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = change_q & irq_en_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_en;
    assign unused_irq_en = irq_en_i;
    assign irq_o         = 1'b0;
`endif
endmodule
